uart_boot_loader: RTL and testbench

Hardware boot loader that receives a program image over UART 8N1 and writes it word by word into instruction/data memory through a Wishbone master port. It holds the CPU in reset while loading, answers ACK/NAK on uart_tx, and releases the CPU on success. It is the parametrised RTL successor to the bench-side byte-serial program load, adding framing, length header, checksum, back-pressure and error reporting.

---
 rtl/uart_boot_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART 8N1 boot loader: receives a framed, length-prefixed, XOR-checked image and
// writes it word by word over a pipelined Wishbone master while holding the CPU in reset.
module uart_boot_loader #(
  parameter int                CLK_DIV   = 434,
  parameter int                WORD_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [WORD_W/8-1:0]   wb_sel_o,
  output logic [ADDR_W-1:0]     wb_adr_o,
  output logic [WORD_W-1:0]     wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_stall_i,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);
  localparam int BPW = WORD_W / 8;
  localparam int CW  = $clog2(CLK_DIV + 1);
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0]     DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]     DIV_HALF  = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0]     BCNT_LAST = BW'(BPW - 1);
  localparam logic [16:0]       MAXW      = 17'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BPW_A     = ADDR_W'(BPW);
  localparam logic [7:0] SOF = 8'hA5, ACK = 8'h06, NAK = 8'h15;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t   rx_st;
  logic        rx_m, rx_s, rx_d;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh, rx_byte;
  logic        rx_valid, rx_ferr;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_m <= 1'b1; rx_s <= 1'b1; rx_d <= 1'b1;
      rx_st <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0;
      rx_sh <= '0; rx_byte <= '0; rx_valid <= 1'b0; rx_ferr <= 1'b0;
    end else begin
      rx_m <= uart_rx; rx_s <= rx_m; rx_d <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (rx_st)
        RX_IDLE:
          if (rx_d && !rx_s) begin rx_st <= RX_START; rx_cnt <= '0; end
        RX_START:
          // a start bit that is high again at mid-point was a glitch
          if (rx_cnt == DIV_HALF) begin
            rx_cnt <= '0; rx_bit <= '0;
            rx_st  <= rx_s ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + CW'(1);
        RX_DATA:
          if (rx_cnt == DIV_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else rx_cnt <= rx_cnt + CW'(1);
        RX_STOP:
          if (rx_cnt == DIV_LAST) begin
            rx_st <= RX_IDLE;
            if (rx_s) begin rx_valid <= 1'b1; rx_byte <= rx_sh; end
            else rx_ferr <= 1'b1;
          end else rx_cnt <= rx_cnt + CW'(1);
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic          tx_start, tx_busy, tx_done;
  logic [7:0]    tx_data;
  logic [8:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      uart_tx <= 1'b1; tx_busy <= 1'b0; tx_done <= 1'b0;
      tx_sh <= '1; tx_bit <= '0; tx_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_start) begin
          tx_busy <= 1'b1; uart_tx <= 1'b0;
          tx_sh <= {1'b1, tx_data}; tx_bit <= '0; tx_cnt <= '0;
        end
      end else if (tx_cnt == DIV_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0; tx_done <= 1'b1;
        end else begin
          uart_tx <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bit  <= tx_bit + 4'd1;
        end
      end else tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // ---------------- loader FSM + bus master ----------------
  typedef enum logic [3:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DRAIN, RESP, DONE, ERR} state_t;
  state_t            state;
  logic [7:0]        n_lo, xsum;
  logic [15:0]       n_words, wcnt;
  logic [BW-1:0]     bcnt;
  logic [WORD_W-1:0] buf_w, word_next;
  logic              buf_full, ck_bad, err_tx, err_ph;
  logic [ADDR_W-1:0] idx;
  logic              ack_now;

  assign ack_now = wb_cyc_o && wb_ack_i;

  // little-endian assembly: each byte enters at the top and earlier bytes move down
  if (WORD_W > 8) begin : g_asm
    logic [WORD_W-9:0] asm_r;
    always_ff @(posedge sys_clk or negedge sys_rst)
      if (!sys_rst) asm_r <= '0;
      else if (state == DATA && rx_valid) asm_r <= word_next[WORD_W-1:8];
    assign word_next = {rx_byte, asm_r};
  end else begin : g_byte
    assign word_next = rx_byte;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= IDLE;
      wb_cyc_o <= 1'b0; wb_stb_o <= 1'b0; wb_we_o <= 1'b0;
      wb_sel_o <= '0; wb_adr_o <= '0; wb_dat_o <= '0;
      cpu_hold <= 1'b1; done <= 1'b0; err <= 1'b0;
      n_lo <= '0; xsum <= '0; n_words <= '0; wcnt <= '0; bcnt <= '0;
      buf_w <= '0; buf_full <= 1'b0; ck_bad <= 1'b0;
      err_tx <= 1'b0; err_ph <= 1'b0; idx <= '0;
      tx_start <= 1'b0; tx_data <= '0;
    end else begin
      tx_start <= 1'b0;

      if (wb_cyc_o) begin
        if (wb_stb_o && !wb_stall_i) wb_stb_o <= 1'b0;
        if (wb_ack_i) begin
          wb_cyc_o <= 1'b0; wb_stb_o <= 1'b0; wb_we_o <= 1'b0; wb_sel_o <= '0;
          buf_full <= 1'b0;
          idx      <= idx + ADDR_W'(1);
        end
      end else if (buf_full && state != ERR) begin
        wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_sel_o <= '1;
        wb_adr_o <= BASE_ADDR + idx * BPW_A;
        wb_dat_o <= buf_w;
      end

      if (rx_ferr && !(state inside {IDLE, DONE, ERR})) begin
        state <= ERR; err_tx <= 1'b1; err_ph <= 1'b0;
      end else begin
        unique case (state)
          IDLE:
            if (rx_valid && rx_byte == SOF) begin
              state <= LEN_LO; err <= 1'b0;
              idx <= '0; xsum <= '0; wcnt <= '0; bcnt <= '0;
            end
          LEN_LO:
            if (rx_valid) begin n_lo <= rx_byte; state <= LEN_HI; end
          LEN_HI:
            if (rx_valid) begin
              n_words <= {rx_byte, n_lo};
              if ({1'b0, rx_byte, n_lo} > MAXW) begin
                state <= ERR; err_tx <= 1'b1; err_ph <= 1'b0;
              end else if ({rx_byte, n_lo} == 16'd0) state <= CSUM;
              else state <= DATA;
            end
          DATA:
            if (rx_valid) begin
              xsum <= xsum ^ rx_byte;
              if (bcnt == BCNT_LAST) begin
                bcnt <= '0;
                // overrun: new word while the previous one still occupies the buffer
                if (buf_full && !ack_now) begin
                  state <= ERR; err_tx <= 1'b1; err_ph <= 1'b0;
                end else begin
                  buf_w <= word_next; buf_full <= 1'b1;
                  wcnt  <= wcnt + 16'd1;
                  if (wcnt == n_words - 16'd1) state <= CSUM;
                end
              end else bcnt <= bcnt + BW'(1);
            end
          CSUM:
            if (rx_valid) begin ck_bad <= (rx_byte != xsum); state <= DRAIN; end
          DRAIN:
            if (!buf_full && !wb_cyc_o) begin
              tx_data <= ck_bad ? NAK : ACK; tx_start <= 1'b1; state <= RESP;
            end
          RESP:
            if (tx_done) begin
              if (!ck_bad) begin state <= DONE; done <= 1'b1; cpu_hold <= 1'b0; end
              else begin state <= ERR; err_tx <= 1'b0; err_ph <= 1'b0; end
            end
          DONE: ;
          ERR: begin
            err <= 1'b1; cpu_hold <= 1'b1; done <= 1'b0;
            // the in-flight write completes; anything still buffered is dropped
            if (!wb_cyc_o) begin
              buf_full <= 1'b0;
              if (!err_tx) state <= IDLE;
              else if (!err_ph) begin
                if (!tx_busy && !tx_start) begin
                  tx_data <= NAK; tx_start <= 1'b1; err_ph <= 1'b1;
                end
              end else if (tx_done) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected bus writes and UART response bytes are
// queued by the stimulus thread and checked by independent bus and serial monitors.
module tb_uart_boot_loader;
  localparam int CLK_DIV = 8;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 32;
  localparam logic [31:0] BASE = 32'h100;

  logic        sys_clk = 1'b0, sys_rst = 1'b0, uart_rx = 1'b1, uart_tx;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_stall_i;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        cpu_hold, done, err;

  uart_boot_loader #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
                     .BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
    .cpu_hold(cpu_hold), .done(done), .err(err));

  always #5 sys_clk = ~sys_clk;

  typedef struct packed { logic [31:0] adr; logic [31:0] dat; } wr_t;
  wr_t        bus_q[$];
  logic [7:0] tx_q[$];
  int n_chk = 0, n_pass = 0, n_wr_done = 0;
  int stall_n = 0, ack_dly = 0;
  bit mon_tx_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Wishbone slave: optional stall, then ack after ack_dly cycles (0 = same cycle as accept)
  initial begin
    wb_ack_i = 1'b0; wb_stall_i = 1'b0;
    forever begin
      @(negedge sys_clk);
      wb_ack_i = 1'b0;
      if (wb_cyc_o && wb_stb_o && sys_rst) begin
        for (int i = 0; i < stall_n; i++) begin wb_stall_i = 1'b1; @(negedge sys_clk); end
        wb_stall_i = 1'b0;
        if (ack_dly > 0) repeat (ack_dly) @(negedge sys_clk);
        wb_ack_i = 1'b1;
      end
    end
  end

  // bus monitor: compares each accepted address phase against the scoreboard
  initial begin
    logic [31:0] hold_adr, hold_dat;
    bit in_stall, moved;
    wr_t e;
    in_stall = 1'b0; moved = 1'b0;
    forever begin
      @(negedge sys_clk); #2;
      if (wb_cyc_o && wb_ack_i) n_wr_done++;
      if (wb_cyc_o && wb_stb_o) begin
        if (in_stall && (wb_adr_o !== hold_adr || wb_dat_o !== hold_dat)) moved = 1'b1;
        hold_adr = wb_adr_o; hold_dat = wb_dat_o;
        if (wb_stall_i) in_stall = 1'b1;
        else begin
          if (bus_q.size() == 0) begin
            n_chk++;
            $display("FAIL bus_write: unexpected write adr=%h dat=%h", wb_adr_o, wb_dat_o);
          end else begin
            e = bus_q.pop_front();
            check("wb_adr", wb_adr_o, e.adr);
            check("wb_dat", wb_dat_o, e.dat);
            check("wb_sel", wb_sel_o, 4'hF);
            check("wb_we", wb_we_o, 1'b1);
            check("stb_stable", moved, 1'b0);
          end
          in_stall = 1'b0; moved = 1'b0;
        end
      end
    end
  end

  // serial monitor: decodes uart_tx 8N1 and compares against queued responses
  initial begin
    logic [7:0] b;
    logic stop_bit;
    forever begin
      @(negedge sys_clk); #2;
      if (sys_rst && uart_tx == 1'b0) begin
        mon_tx_busy = 1'b1;
        repeat (CLK_DIV / 2) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin repeat (CLK_DIV) @(negedge sys_clk); b[i] = uart_tx; end
        repeat (CLK_DIV) @(negedge sys_clk);
        stop_bit = uart_tx;
        check("tx_stop", stop_bit, 1'b1);
        if (tx_q.size() == 0) begin
          n_chk++;
          $display("FAIL tx_byte: unexpected byte %h", b);
        end else check("tx_byte", b, tx_q.pop_front());
        mon_tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    uart_rx = 1'b0; repeat (CLK_DIV) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (CLK_DIV) @(negedge sys_clk); end
    uart_rx = good_stop; repeat (CLK_DIV) @(negedge sys_clk);
    uart_rx = 1'b1; repeat (2) @(negedge sys_clk);
  endtask

  task automatic send_words(input logic [31:0] w[3], input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) send_byte(w[i][8*j +: 8], 1'b1);
  endtask

  task automatic send_frame(input logic [31:0] w[3], input int n, input logic [7:0] ck);
    send_byte(8'hA5, 1'b1); send_byte(n[7:0], 1'b1); send_byte(n[15:8], 1'b1);
    send_words(w, n);
    send_byte(ck, 1'b1);
  endtask

  task automatic push_writes(input logic [31:0] w[3], input int n);
    for (int i = 0; i < n; i++) bus_q.push_back('{adr: BASE + 32'(4 * i), dat: w[i]});
  endtask

  task automatic wait_tx(input string name, input int budget);
    int k = 0;
    while ((tx_q.size() != 0 || mon_tx_busy) && k < budget) begin @(negedge sys_clk); k++; end
    if (k >= budget) begin
      n_chk++;
      $display("FAIL %s: response not seen within %0d cycles, %0d bytes pending", name, budget, tx_q.size());
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b0; repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1; repeat (5) @(negedge sys_clk);
  endtask

  initial begin
    logic [31:0] img[3];
    int k;
    img[0] = 32'h12345678; img[1] = 32'hDEADBEEF; img[2] = 32'h0;

    // reset values
    repeat (3) @(negedge sys_clk); #1;
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("rst_sel", wb_sel_o, 4'h0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_hold_done_err", {cpu_hold, done, err}, 3'b100);
    sys_rst = 1'b1; repeat (5) @(negedge sys_clk);

    // bad checksum, with a 2-cycle rx glitch between header and length
    push_writes(img, 2); tx_q.push_back(8'h15);
    send_byte(8'hA5, 1'b1);
    uart_rx = 1'b0; repeat (2) @(negedge sys_clk); uart_rx = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("glitch_err", err, 1'b0);
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_words(img, 2); send_byte(8'h00, 1'b1);
    wait_tx("nak_bad_csum", 3000);
    repeat (12) @(negedge sys_clk);
    check("csum_err", err, 1'b1);
    check("csum_done", done, 1'b0);
    check("csum_hold", cpu_hold, 1'b1);

    // good retry: XOR of 78 56 34 12 EF BE AD DE is 0x2A
    ack_dly = 1;
    push_writes(img, 2); tx_q.push_back(8'h06);
    send_frame(img, 2, 8'h2A);
    wait_tx("ack_good", 3000);
    check("ack_hold_in_stop", cpu_hold, 1'b1);
    repeat (CLK_DIV + 4) @(negedge sys_clk);
    check("ok_done", done, 1'b1);
    check("ok_hold", cpu_hold, 1'b0);
    check("ok_err_cleared", err, 1'b0);
    check("ok_bus_drained", bus_q.size(), 0);

    // stall 5 cycles and ack 3 cycles late on every write
    do_reset();
    stall_n = 5; ack_dly = 3; n_wr_done = 0;
    push_writes(img, 2); tx_q.push_back(8'h06);
    send_frame(img, 2, 8'h2A);
    wait_tx("ack_stall", 3000);
    repeat (CLK_DIV + 4) @(negedge sys_clk);
    check("stall_done", done, 1'b1);
    check("stall_writes", n_wr_done, 2);
    check("stall_err", err, 1'b0);

    // framing error on the LEN_LO byte
    do_reset();
    stall_n = 0; ack_dly = 0;
    tx_q.push_back(8'h15);
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b0);
    wait_tx("nak_framing", 2000);
    repeat (10) @(negedge sys_clk);
    check("ferr_err", err, 1'b1);
    check("ferr_hold_done", {cpu_hold, done}, 2'b10);

    // length 0x0401 exceeds MAX_WORDS
    n_wr_done = 0; tx_q.push_back(8'h15);
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h04, 1'b1);
    wait_tx("nak_len", 2000);
    repeat (10) @(negedge sys_clk);
    check("len_err", err, 1'b1);
    check("len_no_bus", n_wr_done, 0);

    // overrun: first write's ack withheld past the next word
    img[0] = 32'h03020100; img[1] = 32'h07060504; img[2] = 32'h0B0A0908;
    ack_dly = 1000; n_wr_done = 0;
    push_writes(img, 1); tx_q.push_back(8'h15);
    send_frame(img, 3, 8'h00);
    wait_tx("nak_overrun", 5000);
    repeat (10) @(negedge sys_clk);
    check("ovr_writes", n_wr_done, 1);
    check("ovr_err", err, 1'b1);
    check("ovr_done", done, 1'b0);

    // reset during an open DATA-phase bus cycle
    img[0] = 32'h44332211;
    push_writes(img, 1);
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_words(img, 1);
    k = 0;
    while (!wb_cyc_o && k < 200) begin @(negedge sys_clk); k++; end
    repeat (2) @(negedge sys_clk);
    check("pre_rst_cyc", wb_cyc_o, 1'b1);
    #1 sys_rst = 1'b0;
    #1;
    check("arst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("arst_sel_adr_dat", {wb_sel_o, wb_adr_o, wb_dat_o}, 68'h0);
    check("arst_tx_hold_done_err", {uart_tx, cpu_hold, done, err}, 4'b1100);
    check("end_bus_q", bus_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
